led_pwm_rx: RTL and testbench

LED_PWM_RX -- requirements
Module: led_pwm_rx

---
 rtl/led_pwm_rx_pkg.sv | 17 +
 rtl/led_pwm_ch.sv | 49 ++++
 rtl/led_pwm_rx.sv | 125 ++++++++++++
 tb/tb_led_pwm_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_rx_pkg.sv
// Shared widths and helpers for the UDP-driven LED PWM receiver.
// Imported by the top and by the per-channel PWM slice.
package led_pwm_rx_pkg;

  localparam int CNT_W  = 16;
  localparam int DUTY_W = 8;

  function automatic logic [DUTY_W-1:0] slew_step(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt
  );
    if (cur < tgt) return cur + 1'b1;
    if (cur > tgt) return cur - 1'b1;
    return cur;
  endfunction

endpackage

// File: rtl/led_pwm_ch.sv
// One LED channel: duty register (optional slew), compare, output stage.
// Duty-to-LED latency is two registers: compare flop then output flop.
module led_pwm_ch
  import led_pwm_rx_pkg::*;
#(
  parameter int pwm_w = 10,
  parameter int slew  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] target,
  input  logic [pwm_w-1:0]  cc,
  output logic              led
);

  logic [DUTY_W-1:0] duty;
  logic [pwm_w-1:0]  thr;
  logic              l;

  generate
    if (slew != 0) begin : g_slew
      logic [DUTY_W-1:0] duty_q;
      // step on the cycle cc rolls over to 0
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          duty_q <= '0;
        end else if (&cc) begin
          duty_q <= slew_step(duty_q, target);
        end
      end
      assign duty = duty_q;
    end else begin : g_imm
      assign duty = target;
    end
  endgenerate

  assign thr = pwm_w'(duty) << (pwm_w - DUTY_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l   <= 1'b0;
      led <= 1'b0;
    end else begin
      l   <= cc < thr;
      led <= l;
    end
  end

endmodule

// File: rtl/led_pwm_rx.sv
// Captures LED duty octets from a UDP payload and commits them on a good CRC.
// Feeds n_ch PWM channel slices from a shared free-running counter.
module led_pwm_rx
  import led_pwm_rx_pkg::*;
#(
  parameter int jumbo_dw  = 14,
  parameter int n_ch      = 4,
  parameter int pwm_w     = 10,
  parameter int start_off = 0,
  parameter int slew      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic             strobe,
  input  logic             crc,
  input  logic [7:0]       data_in,
  output logic [n_ch-1:0]  led,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] short_cnt
);

  localparam int CAP_W = $clog2(n_ch + 1);

  logic [jumbo_dw-1:0] oct;
  logic [CAP_W-1:0]    cap;
  logic                live;
  logic                take;
  logic                hit;
  logic                full;
  logic                crc_q;
  logic [pwm_w-1:0]    cc;
  logic [DUTY_W-1:0]   shadow [n_ch];
  logic [DUTY_W-1:0]   target [n_ch];

  // live drops on ready low or reset; only a clean gap re-arms capture
  assign take = strobe & ready & live;
  assign full = cap == CAP_W'(n_ch);

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < n_ch; k++) begin
      if (int'(oct) == start_off + k) hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oct <= '0;
    end else if (!strobe) begin
      oct <= '0;
    end else if (~&oct) begin
      oct <= oct + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live <= 1'b0;
    end else if (!ready) begin
      live <= 1'b0;
    end else if (!strobe) begin
      live <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap <= '0;
    end else if (!ready) begin
      cap <= '0;
    end else if (take) begin
      if (oct == '0) begin
        cap <= CAP_W'(hit);
      end else if (hit && !full) begin
        cap <= cap + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < n_ch; k++) shadow[k] <= '0;
    end else if (take) begin
      for (int k = 0; k < n_ch; k++) begin
        if (int'(oct) == start_off + k) shadow[k] <= data_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q     <= 1'b0;
      good_cnt  <= '0;
      short_cnt <= '0;
      cc        <= '0;
      for (int k = 0; k < n_ch; k++) target[k] <= '0;
    end else begin
      crc_q <= crc & ~strobe;
      cc    <= cc + 1'b1;
      if (crc_q && full) begin
        good_cnt <= good_cnt + 1'b1;
        for (int k = 0; k < n_ch; k++) target[k] <= shadow[k];
      end else if (crc_q) begin
        short_cnt <= short_cnt + 1'b1;
      end
    end
  end

  generate
    for (genvar k = 0; k < n_ch; k++) begin : g_ch
      led_pwm_ch #(
        .pwm_w(pwm_w),
        .slew (slew)
      ) u_ch (
        .clk   (clk),
        .rst   (rst),
        .target(target[k]),
        .cc    (cc),
        .led   (led[k])
      );
    end
  endgenerate

endmodule

// File: tb/tb_led_pwm_rx.sv
// Directed bench: default, start_off=2 and slew=1 instances share stimulus.
// Per-instance ready enables keep each instance's commits separate.
module tb_led_pwm_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0;
  logic        crc = 1'b0;
  logic        rdy_low = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [2:0]  en = 3'b001;
  logic [3:0]  led0, led1, led2;
  logic [15:0] good0, short0, good1, short1, good2, short2;
  logic [11:0] ledall;
  int          ecnt = 0;
  int          total = 0;
  int          bad = 0;
  int          cnts [12];

  typedef struct packed {
    logic [3:0]  n;
    logic [47:0] d;
    logic [3:0]  drop;
    logic        mode;
    logic [15:0] good;
    logic [15:0] shrt;
    logic [31:0] duty;
  } vec_t;

  vec_t vt [6];

  assign ledall = {led2, led1, led0};

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  led_pwm_rx u0 (
    .clk(clk), .rst(rst), .ready(en[0] & ~rdy_low),
    .strobe(strobe), .crc(crc), .data_in(data_in),
    .led(led0), .good_cnt(good0), .short_cnt(short0)
  );

  led_pwm_rx #(.start_off(2), .pwm_w(8)) u1 (
    .clk(clk), .rst(rst), .ready(en[1] & ~rdy_low),
    .strobe(strobe), .crc(crc), .data_in(data_in),
    .led(led1), .good_cnt(good1), .short_cnt(short1)
  );

  led_pwm_rx #(.slew(1), .pwm_w(8)) u2 (
    .clk(clk), .rst(rst), .ready(en[2] & ~rdy_low),
    .strobe(strobe), .crc(crc), .data_in(data_in),
    .led(led2), .good_cnt(good2), .short_cnt(short2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic send_pkt(input logic [47:0] d, input int n,
                          input int drop, input logic mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      strobe  = 1'b1;
      data_in = d[8*i +: 8];
      rdy_low = (i == drop);
      crc     = mode && (i == 1);
    end
    @(negedge clk);
    strobe  = 1'b0;
    data_in = 8'h00;
    rdy_low = 1'b0;
    crc     = !mode;
    @(negedge clk);
    crc = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // one PWM period, aligned so sample n covers compare of cc = n-2
  task automatic measure(input int p);
    for (int b = 0; b < 12; b++) cnts[b] = 0;
    @(negedge clk);
    for (int i = 0; i < p && (ecnt % p) != 2; i++) @(negedge clk);
    for (int i = 0; i < p; i++) begin
      for (int b = 0; b < 12; b++) if (ledall[b]) cnts[b]++;
      if (i < p - 1) @(negedge clk);
    end
  endtask

  initial begin
    vt[0] = '{n: 4'd6, d: 48'h2211_FFC0_8040, drop: 4'hF, mode: 1'b0,
              good: 16'd1, shrt: 16'd0, duty: 32'hFFC0_8040};
    vt[1] = '{n: 4'd3, d: 48'h0000_0003_0201, drop: 4'hF, mode: 1'b0,
              good: 16'd1, shrt: 16'd1, duty: 32'hFFC0_8040};
    vt[2] = '{n: 4'd4, d: 48'h0000_0030_2010, drop: 4'd2, mode: 1'b0,
              good: 16'd1, shrt: 16'd2, duty: 32'hFFC0_8040};
    vt[3] = '{n: 4'd4, d: 48'h0000_7FFE_0100, drop: 4'hF, mode: 1'b0,
              good: 16'd2, shrt: 16'd2, duty: 32'h7FFE_0100};
    vt[4] = '{n: 4'd4, d: 48'h0000_DDCC_BBAA, drop: 4'hF, mode: 1'b1,
              good: 16'd2, shrt: 16'd2, duty: 32'h7FFE_0100};
    vt[5] = '{n: 4'd4, d: 48'h0000_8080_8080, drop: 4'hF, mode: 1'b0,
              good: 16'd3, shrt: 16'd2, duty: 32'h8080_8080};

    repeat (3) @(negedge clk);
    chk("reset_led", int'(ledall), 0);
    chk("reset_good0", int'(good0), 0);
    chk("reset_short0", int'(short0), 0);
    chk("reset_good1", int'(good1), 0);
    chk("reset_good2", int'(good2), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    en = 3'b001;
    for (int i = 0; i < 6; i++) begin
      send_pkt(vt[i].d, int'(vt[i].n), int'(vt[i].drop), vt[i].mode);
      chk($sformatf("v%0d_good", i), int'(good0), int'(vt[i].good));
      chk($sformatf("v%0d_short", i), int'(short0), int'(vt[i].shrt));
      measure(1024);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("v%0d_led%0d_on", i, k), cnts[k],
            4 * int'(vt[i].duty[8*k +: 8]));
      end
    end

    en = 3'b010;
    send_pkt(48'h4030_2010_0000, 6, 15, 1'b0);
    chk("off2_good", int'(good1), 1);
    measure(256);
    chk("off2_led0_on", cnts[4], 16);
    chk("off2_led1_on", cnts[5], 32);
    chk("off2_led2_on", cnts[6], 48);
    chk("off2_led3_on", cnts[7], 64);

    en = 3'b100;
    @(negedge clk);
    for (int i = 0; i < 256 && (ecnt % 256) != 2; i++) @(negedge clk);
    send_pkt(48'h0000_0404_0404, 4, 15, 1'b0);
    chk("slew_good", int'(good2), 1);
    for (int w = 0; w < 5; w++) begin
      measure(256);
      chk($sformatf("slew_p%0d_led0_on", w), cnts[8], (w < 4) ? w + 1 : 4);
    end
    chk("slew_led3_on", cnts[11], 4);

    en = 3'b001;
    @(negedge clk);
    strobe  = 1'b1;
    data_in = 8'h55;
    @(negedge clk);
    data_in = 8'h66;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_led_c%0d", i), int'(ledall), 0);
    end
    chk("rst_good0", int'(good0), 0);
    chk("rst_short0", int'(short0), 0);
    rst     = 1'b0;
    data_in = 8'h77;
    @(negedge clk);
    data_in = 8'h88;
    @(negedge clk);
    strobe  = 1'b0;
    data_in = 8'h00;
    crc     = 1'b1;
    @(negedge clk);
    crc = 1'b0;
    repeat (3) @(negedge clk);
    chk("tail_good0", int'(good0), 0);
    chk("tail_short0", int'(short0), 1);
    send_pkt(48'h0000_FFC0_8040, 4, 15, 1'b0);
    chk("after_rst_good0", int'(good0), 1);
    chk("after_rst_short0", int'(short0), 1);
    measure(1024);
    chk("after_rst_led0_on", cnts[0], 256);
    chk("after_rst_led3_on", cnts[3], 1020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
